mips_regfile_param: RTL and testbench

//  Parametrised MIPS general-purpose register file: next generation of the baseline 2-read/1-write RF.

---
 rtl/mips_regfile_param_if.sv | 27 ++
 rtl/mips_regfile_param.sv | 83 ++++++++
 tb/tb_mips_regfile_param.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_regfile_param_if.sv
// Register-file bus: decode drives read addresses and pending-set,
// writeback drives the write port; the register file returns read data/busy.
interface mips_regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
);
   logic                    RegW;
   logic [ADDR_W-1:0]       DR;
   logic [DATA_W-1:0]       Reg_In;
   logic [NRD*ADDR_W-1:0]   RdAddr;
   logic [NRD*DATA_W-1:0]   RdData;
   logic [NRD-1:0]          RdBusy;
   logic                    PendSet;
   logic [ADDR_W-1:0]       PendAddr;
   logic                    AnyBusy;

   modport master (
      output RegW, DR, Reg_In, RdAddr, PendSet, PendAddr,
      input  RdData, RdBusy, AnyBusy
   );

   modport slave (
      input  RegW, DR, Reg_In, RdAddr, PendSet, PendAddr,
      output RdData, RdBusy, AnyBusy
   );
endinterface

// File: rtl/mips_regfile_param.sv
// Parametrised MIPS register file: NRD registered read ports with write-first
// bypass, one write port, optional hardwired R0, and per-register pending bits
// used by decode to stall on in-flight loads.
module mips_regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input logic                 CLK,
   input logic                 RSTn,
   mips_regfile_param_if.slave rf
);

   localparam int DEPTH = 2**ADDR_W;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [DATA_W-1:0]     reg_q [DEPTH];
   logic [DEPTH-1:0]      pend_q;
   logic [DEPTH-1:0]      pend_d;
   logic                  wr_en;
   logic                  set_en;
   logic [NRD*DATA_W-1:0] rd_d;
   logic [NRD*DATA_W-1:0] rd_q;
   logic [NRD-1:0]        busy_d;
   logic [NRD-1:0]        busy_q;

   // R0 swallows writes and pending-sets when it is hardwired to zero.
   assign wr_en  = rf.RegW    && !(ZR && (rf.DR == '0));
   assign set_en = rf.PendSet && !(ZR && (rf.PendAddr == '0));

   // Post-edge scoreboard: retire clears first, a new load on the same register wins.
   always_comb begin
      pend_d = pend_q;
      if (wr_en) pend_d[rf.DR] = 1'b0;
      if (set_en) pend_d[rf.PendAddr] = 1'b1;
   end

   // Read mux per port with write-first bypass; busy reflects the post-edge scoreboard.
   always_comb begin
      logic [ADDR_W-1:0] a;
      rd_d   = '0;
      busy_d = '0;
      a      = '0;
      for (int k = 0; k < NRD; k++) begin
         a = rf.RdAddr[k*ADDR_W +: ADDR_W];
         if (ZR && (a == '0))
            rd_d[k*DATA_W +: DATA_W] = '0;
         else if (rf.RegW && (rf.DR == a))
            rd_d[k*DATA_W +: DATA_W] = rf.Reg_In;
         else
            rd_d[k*DATA_W +: DATA_W] = reg_q[a];
         busy_d[k] = pend_d[a];
      end
   end

   // Register array update; all registers cleared during reset.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < DEPTH; i++) reg_q[i] <= '0;
      end else if (wr_en) begin
         reg_q[rf.DR] <= rf.Reg_In;
      end
   end

   // Scoreboard and registered read outputs.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         pend_q <= '0;
         rd_q   <= '0;
         busy_q <= '0;
      end else begin
         pend_q <= pend_d;
         rd_q   <= rd_d;
         busy_q <= busy_d;
      end
   end

   assign rf.RdData  = rd_q;
   assign rf.RdBusy  = busy_q;
   assign rf.AnyBusy = |pend_q;

endmodule

// File: tb/tb_mips_regfile_param.sv
// Bench for mips_regfile_param: two instances (32b/5b/2 ports/R0 hardwired and
// 64b/6b/4 ports/ordinary R0) driven together against a write-first array model.
module tb_mips_regfile_param;

   logic CLK;
   logic RSTn;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   chk_en   = 0;

   mips_regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) ifa ();
   mips_regfile_param_if #(.DATA_W(64), .ADDR_W(6), .NRD(4)) ifb ();

   mips_regfile_param #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) dut_a (
      .CLK(CLK), .RSTn(RSTn), .rf(ifa.slave));
   mips_regfile_param #(.DATA_W(64), .ADDR_W(6), .NRD(4), .ZERO_REG(0)) dut_b (
      .CLK(CLK), .RSTn(RSTn), .rf(ifb.slave));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // model state: contents after the most recent edge, and what each port must show
   logic [31:0] ma_reg  [32];
   bit          ma_pend [32];
   logic [31:0] ea_rd   [2];
   bit          ea_busy [2];
   logic [63:0] mb_reg  [64];
   bit          mb_pend [64];
   logic [63:0] eb_rd   [4];
   bit          eb_busy [4];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_models();
      for (int i = 0; i < 32; i++) begin ma_reg[i] = '0; ma_pend[i] = 0; end
      for (int i = 0; i < 64; i++) begin mb_reg[i] = '0; mb_pend[i] = 0; end
      for (int k = 0; k < 2; k++) begin ea_rd[k] = '0; ea_busy[k] = 0; end
      for (int k = 0; k < 4; k++) begin eb_rd[k] = '0; eb_busy[k] = 0; end
   endtask

   // Apply the edge's effects to the architectural state, then read it back:
   // write-first means a port sees the state as it stands after the edge.
   task automatic edge_a();
      int a;
      if (!RSTn) return;
      if (ifa.RegW) begin
         if (ifa.DR != 0) ma_reg[ifa.DR] = ifa.Reg_In;
         ma_pend[ifa.DR] = 0;
      end
      if (ifa.PendSet && ifa.PendAddr != 0) ma_pend[ifa.PendAddr] = 1;
      for (int k = 0; k < 2; k++) begin
         a = int'(ifa.RdAddr[k*5 +: 5]);
         ea_rd[k]   = ma_reg[a];
         ea_busy[k] = ma_pend[a];
      end
   endtask

   task automatic edge_b();
      int a;
      if (!RSTn) return;
      if (ifb.RegW) begin
         mb_reg[ifb.DR]  = ifb.Reg_In;
         mb_pend[ifb.DR] = 0;
      end
      if (ifb.PendSet) mb_pend[ifb.PendAddr] = 1;
      for (int k = 0; k < 4; k++) begin
         a = int'(ifb.RdAddr[k*6 +: 6]);
         eb_rd[k]   = mb_reg[a];
         eb_busy[k] = mb_pend[a];
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      edge_a();
      edge_b();
      @(negedge CLK);
   endtask

   task automatic idle();
      ifa.RegW = 0; ifa.PendSet = 0;
      ifb.RegW = 0; ifb.PendSet = 0;
   endtask

   // Every cycle: each port's data/busy and AnyBusy against the model.
   always @(negedge CLK) begin
      bit any;
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk("a_rd",   64'(ifa.RdData[k*32 +: 32]), 64'(ea_rd[k]));
            chk("a_busy", 64'(ifa.RdBusy[k]),          64'(ea_busy[k]));
         end
         any = 0;
         for (int i = 0; i < 32; i++) any |= ma_pend[i];
         chk("a_any", 64'(ifa.AnyBusy), 64'(any));
         for (int k = 0; k < 4; k++) begin
            chk("b_rd",   ifb.RdData[k*64 +: 64], eb_rd[k]);
            chk("b_busy", 64'(ifb.RdBusy[k]),     64'(eb_busy[k]));
         end
         any = 0;
         for (int i = 0; i < 64; i++) any |= mb_pend[i];
         chk("b_any", 64'(ifb.AnyBusy), 64'(any));
      end
   end

   initial begin
      logic [63:0] pat;
      RSTn = 0;
      ifa.RegW = 0; ifa.DR = '0; ifa.Reg_In = '0; ifa.RdAddr = '0;
      ifa.PendSet = 0; ifa.PendAddr = '0;
      ifb.RegW = 0; ifb.DR = '0; ifb.Reg_In = '0; ifb.RdAddr = '0;
      ifb.PendSet = 0; ifb.PendAddr = '0;
      clear_models();
      tick();
      tick();
      RSTn = 1;
      chk("reset_rd",  64'(ifa.RdData), 64'h0);
      chk("reset_any", 64'(ifa.AnyBusy), 64'h0);
      chk_en = 1;

      // bypass: write and read the same register in one cycle
      ifa.RegW = 1; ifa.DR = 5'd3; ifa.Reg_In = 32'h12345678; ifa.RdAddr = {5'd0, 5'd3};
      tick();
      chk("bypass", 64'(ifa.RdData[31:0]), 64'h12345678);
      idle();
      tick();
      chk("bypass_array", 64'(ifa.RdData[31:0]), 64'h12345678);

      // R0: hardwired on A, ordinary on B (write + set same edge, set wins)
      ifa.RegW = 1; ifa.DR = '0; ifa.Reg_In = 32'hFFFFFFFF;
      ifa.PendSet = 1; ifa.PendAddr = '0; ifa.RdAddr = '0;
      ifb.RegW = 1; ifb.DR = '0; ifb.Reg_In = 64'hFFFFFFFF;
      ifb.PendSet = 1; ifb.PendAddr = '0; ifb.RdAddr = '0;
      tick();
      idle();
      tick();
      chk("r0_zero_rd",   64'(ifa.RdData[31:0]), 64'h0);
      chk("r0_zero_busy", 64'(ifa.RdBusy[0]),    64'h0);
      chk("r0_zero_any",  64'(ifa.AnyBusy),      64'h0);
      chk("r0_plain_rd",  ifb.RdData[63:0],      64'hFFFFFFFF);
      chk("r0_plain_busy", 64'(ifb.RdBusy[0]),   64'h1);

      // scoreboard set, then retire
      ifa.PendSet = 1; ifa.PendAddr = 5'd9;
      tick();
      idle();
      ifa.RdAddr = {5'd0, 5'd9};
      tick();
      chk("pend_busy", 64'(ifa.RdBusy[0]), 64'h1);
      chk("pend_any",  64'(ifa.AnyBusy),   64'h1);
      ifa.RegW = 1; ifa.DR = 5'd9; ifa.Reg_In = 32'h42;
      tick();
      idle();
      chk("retire_busy", 64'(ifa.RdBusy[0]),     64'h0);
      chk("retire_rd",   64'(ifa.RdData[31:0]),  64'h42);
      chk("retire_any",  64'(ifa.AnyBusy),       64'h0);

      // set/clear collision on R4: data updated, still pending
      ifa.RegW = 1; ifa.DR = 5'd4; ifa.Reg_In = 32'hA5A5_0004;
      ifa.PendSet = 1; ifa.PendAddr = 5'd4; ifa.RdAddr = {5'd4, 5'd4};
      tick();
      idle();
      chk("collide_rd",   64'(ifa.RdData[31:0]), 64'hA5A50004);
      chk("collide_busy", 64'(ifa.RdBusy[1]),    64'h1);

      // reset asserted between edges
      ifa.RegW = 1; ifa.DR = 5'd5; ifa.Reg_In = 32'hDEADBEEF;
      ifa.PendSet = 1; ifa.PendAddr = 5'd7; ifa.RdAddr = {5'd7, 5'd5};
      tick();
      idle();
      tick();
      chk("pre_reset_rd",   64'(ifa.RdData[31:0]), 64'hDEADBEEF);
      chk("pre_reset_busy", 64'(ifa.RdBusy[1]),    64'h1);
      #2 RSTn = 0;
      #1;
      chk("async_rd",   64'(ifa.RdData), 64'h0);
      chk("async_busy", 64'(ifa.RdBusy), 64'h0);
      chk("async_any",  64'(ifa.AnyBusy), 64'h0);
      clear_models();
      ifa.RegW = 1; ifa.DR = 5'd6; ifa.Reg_In = 32'h1;
      tick();
      idle();
      RSTn = 1;
      tick();
      chk("post_reset_r5", 64'(ifa.RdData[31:0]), 64'h0);
      chk("post_reset_r7", 64'(ifa.RdBusy[1]),    64'h0);

      // wide sweep on B: fill every register, read back on all ports
      for (int i = 0; i < 64; i++) begin
         ifb.RegW = 1; ifb.DR = 6'(i);
         ifb.Reg_In = 64'(i) * 64'h0101010101010101;
         ifb.RdAddr = 24'($urandom);
         tick();
      end
      idle();
      for (int i = 0; i < 64; i++) begin
         ifb.RdAddr = {6'((i + 7) % 64), 6'(i), 6'(63 - i), 6'(i)};
         tick();
         pat = 64'(i) * 64'h0101010101010101;
         chk("sweep_p0", ifb.RdData[63:0],    pat);
         chk("sweep_p2", ifb.RdData[191:128], pat);
      end

      // randomized traffic on both instances
      for (int n = 0; n < 1500; n++) begin
         ifa.RegW     = ($urandom_range(0, 2) == 0);
         ifa.DR       = ($urandom & 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ifa.Reg_In   = $urandom;
         ifa.PendSet  = ($urandom_range(0, 3) == 0);
         ifa.PendAddr = ($urandom & 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         for (int k = 0; k < 2; k++)
            ifa.RdAddr[k*5 +: 5] = ($urandom & 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ifb.RegW     = ($urandom_range(0, 2) == 0);
         ifb.DR       = ($urandom & 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         ifb.Reg_In   = {$urandom, $urandom};
         ifb.PendSet  = ($urandom_range(0, 3) == 0);
         ifb.PendAddr = ($urandom & 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         for (int k = 0; k < 4; k++)
            ifb.RdAddr[k*6 +: 6] = ($urandom & 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         tick();
      end
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
